sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- SPI-mode SD card emulator; the card-side counterpart of the SD SPI host session engine.
- Sits on the card side of the spi_ssn/spi_sck/spi_mosi/spi_miso bus.
- Decodes 6-byte host commands and returns R1/R3/R7 responses after a programmable Ncr gap.
- Serves single-block reads (CMD17): start token 0xFE, 512 bytes from a user buffer port, 2 CRC bytes.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between the command's last byte and the response (1..8).
- ACMD41_POLLS, 2, number of ACMD41 commands answered with 0x01 before 0x00 is returned.
- OCR, 32'hC0FF8000, value returned in the R3 payload of CMD58.
- RD_GAP_BYTES, 1, minimum 0xFF bytes sent after the R1 of CMD17 before the token.

Ports:
- clk  in  1  system clock; must run at least 8x the spi_sck frequency
- rst  in  1  synchronous active-high reset
- spi_ssn  in  1  chip select from host, active low
- spi_sck  in  1  SPI clock from host, idles high
- spi_mosi  in  1  host data, sampled on spi_sck rising edge
- spi_miso  out  1  card data, updated after spi_sck falling edge
- spi_miso_oe  out  1  output enable for miso, high while spi_ssn is low
- cmd_valid  out  1  one-cycle pulse when a complete command is decoded
- cmd_idx  out  6  command index, held until the next cmd_valid
- cmd_arg  out  32  command argument, held until the next cmd_valid
- rd_ready  in  1  user block buffer is ready for the current CMD17 address
- rd_en  out  1  one-cycle read strobe to the user buffer
- rd_idx  out  9  byte index 0..511
- rd_data  in  8  buffer data, valid exactly 1 clk after rd_en
- card_idle  out  1  R1 idle bit state

Behaviour:
- Input sync: spi_ssn, spi_sck and spi_mosi each pass through a 2-FF synchronizer; sck edges are detected on the synchronized signal. Edge-to-action latency is at most 3 clk.
- Reset values: spi_miso=1, spi_miso_oe=0, cmd_valid=0, cmd_idx=0, cmd_arg=0, rd_en=0, rd_idx=0, card_idle=1, ACMD41 poll counter=0, app_cmd flag=0, state=S_HUNT.
- Bit layer:
  - MSB first.
  - Sample mosi on sck rise; bit counter 0..7, byte complete on the 8th rise.
  - tx shift register loads the next byte at byte completion. Its MSB is driven on the first following sck fall; each later fall drives the next bit.
  - While no byte is queued, tx byte = 0xFF.
- spi_ssn high at any time, including mid-byte or mid-block:
  - bit counter cleared, state forced to S_HUNT, spi_miso=1, oe=0, rd_en=0.
  - card_idle and the poll counter are kept.
- FSM:
  - S_HUNT: discard bytes until a byte with [7:6]=2'b01; that byte is command byte 0 -> S_CMD.
  - S_CMD: collect bytes 1..5 (arg[31:24]..arg[7:0], then CRC, which is not checked). After byte 5: pulse cmd_valid, load Ncr counter -> S_NCR.
  - S_NCR: send NCR_BYTES x 0xFF -> S_RESP.
  - S_RESP: send R1, then 4 trailing bytes for R3 (OCR) or R7 ({20'h0,arg[11:0]}, echoing voltage and check pattern), then go to S_HUNT. For an accepted CMD17, go to S_RDWAIT instead.
  - S_RDWAIT: send 0xFF for at least RD_GAP_BYTES and until rd_ready is sampled high at a byte boundary -> S_TOKEN.
  - S_TOKEN: send 0xFE. At the same time issue rd_en with rd_idx=0, latch rd_data -> S_DATA.
  - S_DATA: send the latched byte. At each byte boundary prefetch index+1 (rd_en pulse). After index 511 -> S_CRC.
  - S_CRC: send 0xFF, 0xFF -> S_HUNT.
- Command decode (R1 bit0 = card_idle):
  - CMD0: card_idle=1, poll counter=0, R1=0x01.
  - CMD8: R7.
  - CMD55: set app_cmd, R1.
  - CMD41 with app_cmd set:
    - poll counter < ACMD41_POLLS: counter+1, R1=0x01.
    - otherwise: card_idle=0, R1=0x00.
  - CMD58: R3.
  - CMD16: R1.
  - CMD17: R1 when card_idle=0; when card_idle=1, R1=0x05 and no data phase.
  - Any other index, or CMD41 without app_cmd: R1 = {5'b0, 1'b1 (illegal), 1'b0, card_idle}.
  - app_cmd clears on every command other than CMD55.
- A command byte arriving while a response or data phase is in progress is ignored (no CMD12 support).
- rst asserted mid-operation: all state returns to reset values on the next clk.

Decomposition:
- Package sd_spi_pkg holds:
  - state enum (S_HUNT, S_CMD, S_NCR, S_RESP, S_RDWAIT, S_TOKEN, S_DATA, S_CRC);
  - command index constants CMD0/8/16/17/41/55/58;
  - constants R1_IDLE, R1_ILLEGAL, TOKEN_START=8'hFE, BLOCK_LEN=512.
- One sub-module, spi_slave_byte: synchronizers, edge detect, rx/tx shifters. It provides rx_byte/rx_valid, a tx_load strobe at byte boundary, and ssn abort.

Test Plan:
- CMD0 (40 00 00 00 00 95) -> cmd_valid with idx=0, arg=0; miso bytes after the command: FF, 01.
- CMD8 arg 0x000001AA -> FF, 01, 00, 00, 01, AA; card_idle stays 1.
- CMD55+CMD41 loop with ACMD41_POLLS=2 -> R1 sequence 01, 01, 00; card_idle falls after the third ACMD41; then CMD58 -> 00, C0, FF, 80, 00.
- CMD17 arg 0x10, rd_ready delayed 20 bytes, buffer = idx[7:0] -> ≥20 FF bytes, FE, 00, 01..FF, 00..FF, then FF, FF; exactly 512 rd_en pulses with rd_idx 0..511.
- CMD17 while card_idle=1 -> R1=05, then only FF; no rd_en. CMD63 -> R1=05 (idle) or 04 (ready).
- spi_ssn raised at data byte 100, then a new CMD0 -> no further rd_en; response FF, 01 to the new command.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_NCR, S_RESP, S_RDWAIT, S_TOKEN, S_DATA, S_CRC
  } state_e;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [7:0] R1_IDLE     = 8'h01;
  localparam logic [7:0] R1_ILLEGAL  = 8'h04;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam int unsigned BLOCK_LEN  = 512;

endpackage

// File: rtl/sd_spi_responder_if.sv
// SPI pins between an SD host (master) and the card-side responder (slave).
interface sd_spi_responder_if;
  logic spi_ssn;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_ssn, spi_sck, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave  (input spi_ssn, spi_sck, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_slave_byte.sv
// Oversampled SPI mode-3 slave byte engine: synchronizers, edge detect, rx/tx shifters.
module spi_slave_byte (
  input  logic               clk,
  input  logic               rst,
  sd_spi_responder_if.slave  spi,
  input  logic [7:0]         tx_byte,
  output logic [7:0]         rx_byte,
  output logic               rx_valid,
  output logic               tx_load,
  output logic               abort
);
  logic [1:0] ssn_sync_q, mosi_sync_q;
  logic [2:0] sck_sync_q;
  logic       ssn_s, mosi_s, sck_rise, sck_fall;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sr_q, tx_sr_q;
  logic       rx_valid_q, miso_q, oe_q;

  assign ssn_s    = ssn_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

  assign rx_byte         = rx_sr_q;
  assign rx_valid        = rx_valid_q;
  assign tx_load         = rx_valid_q;
  assign abort           = ssn_s;
  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ssn_sync_q  <= 2'b11;
      sck_sync_q  <= 3'b111;
      mosi_sync_q <= 2'b11;
    end else begin
      ssn_sync_q  <= {ssn_sync_q[0], spi.spi_ssn};
      sck_sync_q  <= {sck_sync_q[1:0], spi.spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= 8'hFF;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      oe_q       <= ~ssn_s;
      if (ssn_s) begin
        bit_cnt_q <= '0;
        tx_sr_q   <= 8'hFF;
        miso_q    <= 1'b1;
      end else begin
        if (sck_rise) begin
          rx_sr_q   <= {rx_sr_q[6:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_valid_q <= 1'b1;
        end
        // Load lands between the 8th rise and the following fall, so the fall drives the new MSB.
        if (rx_valid_q) begin
          tx_sr_q <= tx_byte;
        end else if (sck_fall) begin
          miso_q  <= tx_sr_q[7];
          tx_sr_q <= {tx_sr_q[6:0], 1'b1};
        end
      end
    end
  end
endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: command decode, R1/R3/R7 responses and CMD17 block reads.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_BYTES    = 1,
  parameter int unsigned ACMD41_POLLS = 2,
  parameter logic [31:0] OCR          = 32'hC0FF8000,
  parameter int unsigned RD_GAP_BYTES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sd_spi_responder_if.slave  spi,
  output logic               cmd_valid,
  output logic [5:0]         cmd_idx,
  output logic [31:0]        cmd_arg,
  input  logic               rd_ready,
  output logic               rd_en,
  output logic [8:0]         rd_idx,
  input  logic [7:0]         rd_data,
  output logic               card_idle
);
  localparam logic [2:0]  NcrLoad      = 3'(NCR_BYTES - 1);
  localparam logic [7:0]  PollMax      = 8'(ACMD41_POLLS);
  localparam logic [15:0] RdGap        = 16'(RD_GAP_BYTES);
  localparam logic [8:0]  LastIdx      = 9'(BLOCK_LEN - 1);
  localparam logic [8:0]  LastPrefetch = 9'(BLOCK_LEN - 2);

  logic [7:0] rx_byte, tx_byte;
  logic       rx_valid, tx_load, abort;

  spi_slave_byte u_byte (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .tx_byte  (tx_byte),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_load  (tx_load),
    .abort    (abort)
  );

  state_e      state_q, state_d;
  logic [2:0]  cmd_cnt_q, cmd_cnt_d, ncr_cnt_q, ncr_cnt_d, resp_cnt_q, resp_cnt_d;
  logic [5:0]  idx_sh_q, idx_sh_d, cmd_idx_q, cmd_idx_d;
  logic [31:0] arg_sh_q, arg_sh_d, cmd_arg_q, cmd_arg_d, tail_q, tail_d;
  logic        cmd_valid_q, cmd_valid_d, card_idle_q, card_idle_d, app_cmd_q, app_cmd_d;
  logic [7:0]  polls_q, polls_d, r1_q, r1_d, data_q;
  logic        long_q, long_d, rd_go_q, rd_go_d, crc_cnt_q, crc_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [8:0]  byte_idx_q, byte_idx_d, rd_idx_q, rd_idx_d;
  logic        rd_en_q, rd_en_d, rd_pend_q;

  logic [7:0]  dec_r1, dec_polls;
  logic [31:0] dec_tail;
  logic        dec_idle, dec_app, dec_long, dec_rd;

  // Command decode; applied only when the CRC byte completes.
  always_comb begin
    dec_r1    = R1_ILLEGAL | {7'b0, card_idle_q};
    dec_idle  = card_idle_q;
    dec_polls = polls_q;
    dec_app   = 1'b0;
    dec_long  = 1'b0;
    dec_tail  = '0;
    dec_rd    = 1'b0;
    case (idx_sh_q)
      CMD0: begin
        dec_idle  = 1'b1;
        dec_polls = '0;
        dec_r1    = R1_IDLE;
      end
      CMD8: begin
        dec_r1   = {7'b0, card_idle_q};
        dec_long = 1'b1;
        dec_tail = {20'h0, arg_sh_q[11:0]};
      end
      CMD16: dec_r1 = {7'b0, card_idle_q};
      CMD17: begin
        if (!card_idle_q) begin
          dec_r1 = 8'h00;
          dec_rd = 1'b1;
        end
      end
      CMD41: begin
        if (app_cmd_q) begin
          if (polls_q < PollMax) begin
            dec_polls = polls_q + 8'd1;
            dec_r1    = R1_IDLE;
          end else begin
            dec_idle = 1'b0;
            dec_r1   = 8'h00;
          end
        end
      end
      CMD55: begin
        dec_app = 1'b1;
        dec_r1  = {7'b0, card_idle_q};
      end
      CMD58: begin
        dec_r1   = {7'b0, card_idle_q};
        dec_long = 1'b1;
        dec_tail = OCR;
      end
      default: ;
    endcase
  end

  // Each byte boundary chooses the byte that goes out next and advances the state.
  always_comb begin
    state_d = state_q;  cmd_cnt_d = cmd_cnt_q;  idx_sh_d = idx_sh_q;  arg_sh_d = arg_sh_q;
    cmd_valid_d = 1'b0; cmd_idx_d = cmd_idx_q;  cmd_arg_d = cmd_arg_q;
    card_idle_d = card_idle_q; polls_d = polls_q; app_cmd_d = app_cmd_q;
    r1_d = r1_q; tail_d = tail_q; long_d = long_q; rd_go_d = rd_go_q;
    ncr_cnt_d = ncr_cnt_q; resp_cnt_d = resp_cnt_q; gap_cnt_d = gap_cnt_q;
    byte_idx_d = byte_idx_q; crc_cnt_d = crc_cnt_q;
    rd_en_d = 1'b0; rd_idx_d = rd_idx_q; tx_byte = 8'hFF;
    if (abort) begin
      state_d = S_HUNT;
    end else if (tx_load) begin
      unique case (state_q)
        S_HUNT: begin
          if (rx_valid && rx_byte[7:6] == 2'b01) begin
            idx_sh_d  = rx_byte[5:0];
            cmd_cnt_d = 3'd1;
            state_d   = S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_cnt_q == 3'd5) begin
            cmd_valid_d = 1'b1;
            cmd_idx_d   = idx_sh_q;
            cmd_arg_d   = arg_sh_q;
            card_idle_d = dec_idle;
            polls_d     = dec_polls;
            app_cmd_d   = dec_app;
            r1_d        = dec_r1;
            tail_d      = dec_tail;
            long_d      = dec_long;
            rd_go_d     = dec_rd;
            ncr_cnt_d   = NcrLoad;
            state_d     = S_NCR;
          end else begin
            arg_sh_d  = {arg_sh_q[23:0], rx_byte};
            cmd_cnt_d = cmd_cnt_q + 3'd1;
          end
        end
        S_NCR: begin
          if (ncr_cnt_q == '0) begin
            tx_byte    = r1_q;
            resp_cnt_d = '0;
            state_d    = S_RESP;
          end else begin
            ncr_cnt_d = ncr_cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (long_q && resp_cnt_q != 3'd4) begin
            tx_byte    = tail_q[31:24];
            tail_d     = {tail_q[23:0], 8'h00};
            resp_cnt_d = resp_cnt_q + 3'd1;
          end else if (rd_go_q) begin
            gap_cnt_d = 16'd1;
            state_d   = S_RDWAIT;
          end else begin
            state_d = S_HUNT;
          end
        end
        S_RDWAIT: begin
          if (gap_cnt_q >= RdGap && rd_ready) begin
            tx_byte  = TOKEN_START;
            rd_en_d  = 1'b1;
            rd_idx_d = '0;
            state_d  = S_TOKEN;
          end else if (gap_cnt_q != '1) begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
        S_TOKEN: begin
          tx_byte    = data_q;
          byte_idx_d = '0;
          rd_en_d    = 1'b1;
          rd_idx_d   = 9'd1;
          state_d    = S_DATA;
        end
        S_DATA: begin
          if (byte_idx_q == LastIdx) begin
            crc_cnt_d = 1'b0;
            state_d   = S_CRC;
          end else begin
            tx_byte    = data_q;
            byte_idx_d = byte_idx_q + 9'd1;
            // Keep one byte prefetched ahead of the byte now leaving the shifter.
            if (byte_idx_q != LastPrefetch) begin
              rd_en_d  = 1'b1;
              rd_idx_d = byte_idx_q + 9'd2;
            end
          end
        end
        S_CRC: begin
          if (!crc_cnt_q) crc_cnt_d = 1'b1;
          else            state_d   = S_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;  cmd_cnt_q <= '0;  idx_sh_q <= '0;  arg_sh_q <= '0;
      cmd_valid_q <= 1'b0; cmd_idx_q <= '0; cmd_arg_q <= '0;
      card_idle_q <= 1'b1; polls_q <= '0;   app_cmd_q <= 1'b0;
      r1_q <= 8'hFF; tail_q <= '0; long_q <= 1'b0; rd_go_q <= 1'b0;
      ncr_cnt_q <= '0; resp_cnt_q <= '0; gap_cnt_q <= '0;
      byte_idx_q <= '0; crc_cnt_q <= 1'b0; rd_en_q <= 1'b0; rd_idx_q <= '0;
    end else begin
      state_q <= state_d;  cmd_cnt_q <= cmd_cnt_d;  idx_sh_q <= idx_sh_d;  arg_sh_q <= arg_sh_d;
      cmd_valid_q <= cmd_valid_d; cmd_idx_q <= cmd_idx_d; cmd_arg_q <= cmd_arg_d;
      card_idle_q <= card_idle_d; polls_q <= polls_d; app_cmd_q <= app_cmd_d;
      r1_q <= r1_d; tail_q <= tail_d; long_q <= long_d; rd_go_q <= rd_go_d;
      ncr_cnt_q <= ncr_cnt_d; resp_cnt_q <= resp_cnt_d; gap_cnt_q <= gap_cnt_d;
      byte_idx_q <= byte_idx_d; crc_cnt_q <= crc_cnt_d; rd_en_q <= rd_en_d; rd_idx_q <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      data_q    <= 8'hFF;
    end else begin
      rd_pend_q <= rd_en_q;
      if (rd_pend_q) data_q <= rd_data;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_arg   = cmd_arg_q;
  assign rd_en     = rd_en_q;
  assign rd_idx    = rd_idx_q;
  assign card_idle = card_idle_q;
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder acting as host on the SPI bus.
module tb_sd_spi_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, rd_ready, rd_en, card_idle;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [8:0]  rd_idx;
  logic [7:0]  rd_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cv_cnt  = 0;
  int rd_cnt  = 0;
  int rd_err  = 0;
  int rd_exp  = 0;

  always #5 clk = ~clk;

  sd_spi_responder_if spi_bus ();

  sd_spi_responder dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi_bus),
    .cmd_valid (cmd_valid),
    .cmd_idx   (cmd_idx),
    .cmd_arg   (cmd_arg),
    .rd_ready  (rd_ready),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .card_idle (card_idle)
  );

  // Block buffer: byte i holds i[7:0], one clk read latency.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= rd_idx[7:0];
  end

  always_ff @(posedge clk) begin
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (!(rd_idx == 9'd0 || 32'(rd_idx) == rd_exp)) rd_err <= rd_err + 1;
      rd_exp <= 32'(rd_idx) + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_bus.spi_sck  = 1'b0;
      spi_bus.spi_mosi = tx[i];
      #40;
      rx[i] = spi_bus.spi_miso;
      spi_bus.spi_sck = 1'b1;
      #40;
    end
  endtask

  // Sends a command, then clocks n filler bytes and checks them against exp (left-aligned).
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] crc, input int n, input logic [47:0] exp);
    logic [7:0]  b;
    logic [47:0] e;
    xfer({2'b01, idx}, b);
    xfer(arg[31:24], b);
    xfer(arg[23:16], b);
    xfer(arg[15:8], b);
    xfer(arg[7:0], b);
    xfer(crc, b);
    e = exp;
    for (int k = 0; k < n; k++) begin
      xfer(8'hFF, b);
      check($sformatf("%s_b%0d", tag, k), 32'(b), 32'(e[47:40]));
      e = e << 8;
    end
  endtask

  logic [7:0] b;
  int         nff, dmis, c0, c1;
  logic       got;

  initial begin
    rst = 1'b1;
    rd_ready = 1'b0;
    spi_bus.spi_ssn  = 1'b1;
    spi_bus.spi_sck  = 1'b1;
    spi_bus.spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi_bus.spi_miso), 32'd1);
    check("rst_oe", 32'(spi_bus.spi_miso_oe), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_idx", 32'(cmd_idx), 32'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_idx", 32'(rd_idx), 32'd0);
    check("rst_card_idle", 32'(card_idle), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    spi_bus.spi_ssn = 1'b0;
    repeat (8) @(negedge clk);
    check("oe_low_ssn", 32'(spi_bus.spi_miso_oe), 32'd1);

    run_cmd("CMD0", 6'd0, 32'h0, 8'h95, 2, 48'hFF01_0000_0000);
    check("CMD0_idx", 32'(cmd_idx), 32'd0);
    check("CMD0_arg", cmd_arg, 32'd0);
    check("CMD0_cv", 32'(cv_cnt), 32'd1);

    run_cmd("CMD8", 6'd8, 32'h0000_01AA, 8'h87, 6, 48'hFF01_0000_01AA);
    check("CMD8_idx", 32'(cmd_idx), 32'd8);
    check("CMD8_arg", cmd_arg, 32'h0000_01AA);
    check("CMD8_idle", 32'(card_idle), 32'd1);
    check("CMD8_cv", 32'(cv_cnt), 32'd2);

    run_cmd("CMD63_idle", 6'd63, 32'h0, 8'hFF, 2, 48'hFF05_0000_0000);
    run_cmd("CMD17_idle", 6'd17, 32'h0, 8'hFF, 6, 48'hFF05_FFFF_FFFF);
    check("CMD17_idle_rd", 32'(rd_cnt), 32'd0);
    run_cmd("CMD41_noapp", 6'd41, 32'h4000_0000, 8'hFF, 2, 48'hFF05_0000_0000);

    run_cmd("CMD55_1", 6'd55, 32'h0, 8'hFF, 2, 48'hFF01_0000_0000);
    run_cmd("ACMD41_1", 6'd41, 32'h4000_0000, 8'hFF, 2, 48'hFF01_0000_0000);
    run_cmd("CMD55_2", 6'd55, 32'h0, 8'hFF, 2, 48'hFF01_0000_0000);
    run_cmd("ACMD41_2", 6'd41, 32'h4000_0000, 8'hFF, 2, 48'hFF01_0000_0000);
    check("idle_after_2", 32'(card_idle), 32'd1);
    run_cmd("CMD55_3", 6'd55, 32'h0, 8'hFF, 2, 48'hFF01_0000_0000);
    run_cmd("ACMD41_3", 6'd41, 32'h4000_0000, 8'hFF, 2, 48'hFF00_0000_0000);
    check("idle_after_3", 32'(card_idle), 32'd0);

    run_cmd("CMD58", 6'd58, 32'h0, 8'hFF, 6, 48'hFF00_C0FF_8000);
    run_cmd("CMD63_ready", 6'd63, 32'h0, 8'hFF, 2, 48'hFF04_0000_0000);
    run_cmd("CMD16", 6'd16, 32'h0000_0200, 8'hFF, 2, 48'hFF00_0000_0000);

    // Block read with the buffer held off for 20 byte times.
    c0 = rd_cnt;
    run_cmd("CMD17a", 6'd17, 32'h0000_0010, 8'hFF, 2, 48'hFF00_0000_0000);
    check("CMD17a_arg", cmd_arg, 32'h0000_0010);
    nff = 0;
    for (int k = 0; k < 20; k++) begin
      xfer(8'hFF, b);
      if (b == 8'hFF) nff++;
    end
    check("CMD17a_wait_ff", 32'(nff), 32'd20);
    rd_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      xfer(8'hFF, b);
      if (b == 8'hFE) got = 1'b1;
      else if (b == 8'hFF) nff++;
    end
    check("CMD17a_token", 32'(got), 32'd1);
    check("CMD17a_gap_min", 32'(nff >= 20), 32'd1);
    dmis = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, b);
      if (b != 8'(i)) dmis++;
    end
    check("CMD17a_data", 32'(dmis), 32'd0);
    xfer(8'hFF, b);
    check("CMD17a_crc0", 32'(b), 32'hFF);
    xfer(8'hFF, b);
    check("CMD17a_crc1", 32'(b), 32'hFF);
    check("CMD17a_rd_cnt", 32'(rd_cnt - c0), 32'd512);
    check("CMD17a_rd_seq", 32'(rd_err), 32'd0);

    // Second read, abandoned by raising ssn part-way through data byte 100.
    c0 = rd_cnt;
    run_cmd("CMD17b", 6'd17, 32'h0000_0020, 8'hFF, 2, 48'hFF00_0000_0000);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      xfer(8'hFF, b);
      if (b == 8'hFE) got = 1'b1;
    end
    check("CMD17b_token", 32'(got), 32'd1);
    for (int i = 0; i < 100; i++) xfer(8'hFF, b);
    for (int i = 0; i < 4; i++) begin
      spi_bus.spi_sck = 1'b0;
      #40;
      spi_bus.spi_sck = 1'b1;
      #40;
    end
    spi_bus.spi_ssn = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_oe", 32'(spi_bus.spi_miso_oe), 32'd0);
    check("abort_miso", 32'(spi_bus.spi_miso), 32'd1);
    check("abort_rd_cnt", 32'(rd_cnt - c0), 32'd102);
    check("abort_idle_kept", 32'(card_idle), 32'd0);
    c1 = rd_cnt;
    rd_ready = 1'b0;
    spi_bus.spi_ssn = 1'b0;
    repeat (8) @(negedge clk);
    run_cmd("CMD0b", 6'd0, 32'h0, 8'h95, 2, 48'hFF01_0000_0000);
    check("CMD0b_no_rd", 32'(rd_cnt - c1), 32'd0);
    check("CMD0b_idle", 32'(card_idle), 32'd1);

    // Reset in the middle of a session.
    run_cmd("CMD16b", 6'd16, 32'h0000_0200, 8'hFF, 2, 48'hFF01_0000_0000);
    check("CMD16b_idx", 32'(cmd_idx), 32'd16);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_cmd_idx", 32'(cmd_idx), 32'd0);
    check("rst2_cmd_arg", cmd_arg, 32'd0);
    check("rst2_oe", 32'(spi_bus.spi_miso_oe), 32'd0);
    check("rst2_idle", 32'(card_idle), 32'd1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
